// File: rtl/zz_varint_seq_pkg.sv
// Shared types and constants for the zigzag/varint field serializer.
package zz_pkg;

  typedef enum logic [1:0] {
    ZZ_UINT   = 2'd0,
    ZZ_INT32  = 2'd1,
    ZZ_SINT32 = 2'd2,
    ZZ_SINT64 = 2'd3
  } zz_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } zz_state_t;

  localparam int VARINT_GRP_W     = 7;
  localparam int MAX_VARINT_BYTES = 10;
  localparam int BCNT_W           = 4;

  // Index of the last legal byte of a varint; a continuation here is an overflow.
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MAX_VARINT_BYTES - 1);

  function automatic logic varint_cont(input logic [63:0] sh);
    return |sh[63:VARINT_GRP_W];
  endfunction

endpackage

// File: rtl/zz_varint_seq_xform.sv
// Combinational protobuf scalar transform: zigzag for sint32/sint64,
// sign extension for int32, passthrough for uint.
module zz_xform
  import zz_pkg::*;
(
  input  logic [63:0] in_val,
  input  zz_mode_t    in_mode,
  output logic [63:0] v64
);

  logic [31:0] zz32;
  logic [63:0] zz64;

  // Zigzag maps n to (n << 1) ^ (n >> (w-1)) with an arithmetic shift.
  assign zz32 = {in_val[30:0], 1'b0} ^ {32{in_val[31]}};
  assign zz64 = {in_val[62:0], 1'b0} ^ {64{in_val[63]}};

  always_comb begin
    v64 = in_val;
    case (in_mode)
      ZZ_UINT:   v64 = in_val;
      ZZ_INT32:  v64 = {{32{in_val[31]}}, in_val[31:0]};
      ZZ_SINT32: v64 = {32'b0, zz32};
      ZZ_SINT64: v64 = zz64;
      default:   v64 = in_val;
    endcase
  end

endmodule

// File: rtl/zz_varint_seq.sv
// Field-value serializer: transforms one scalar and emits its base-128 varint
// one byte per cycle. Define ZZ_STATS_EN to add field/byte statistics counters.
module zz_varint_seq
  import zz_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_val,
  input  logic [1:0]  in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        busy
`ifdef ZZ_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] fld_cnt,
  output logic [CNT_W-1:0] byte_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  zz_state_t         state_reg, state_next;
  logic [63:0]       sh_reg, sh_next;
  logic [BCNT_W-1:0] bcnt_reg, bcnt_next;

  logic [63:0] v64;
  logic        cont;
  logic        emit;
  logic        in_fire;
  logic        out_fire;

  zz_xform u_xform (
    .in_val  (in_val),
    .in_mode (zz_mode_t'(in_mode)),
    .v64     (v64)
  );

  assign cont = varint_cont(sh_reg);
  assign emit = (state_reg == ST_EMIT);

  // Outputs are forced to their idle values while rst is high so the reset
  // cycle itself presents no byte and accepts no field.
  assign out_valid = emit & ~rst;
  assign busy      = emit & ~rst;
  assign out_byte  = rst ? 8'h00 : {cont, sh_reg[VARINT_GRP_W-1:0]};
  assign out_last  = rst | ~cont;
  assign in_ready  = ~rst & (emit ? (out_ready & ~cont) : 1'b1);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      sh_reg    <= '0;
      bcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      sh_reg    <= sh_next;
      bcnt_reg  <= bcnt_next;
    end
  end

  // A new field can only be accepted in IDLE or on the final byte, so the
  // load path has priority over both the shift and the return to IDLE.
  always_comb begin
    state_next = state_reg;
    sh_next    = sh_reg;
    bcnt_next  = bcnt_reg;
    if (in_fire) begin
      state_next = ST_EMIT;
      sh_next    = v64;
      bcnt_next  = '0;
    end else if (out_fire && out_last) begin
      state_next = ST_IDLE;
    end else if (out_fire) begin
      sh_next   = sh_reg >> VARINT_GRP_W;
      bcnt_next = bcnt_reg + BCNT_W'(1);
    end
  end

  a_varint_len : assert property (@(posedge clk) disable iff (rst)
    !(emit && (bcnt_reg == BCNT_LAST) && cont));

`ifdef ZZ_STATS_EN
  logic [CNT_W-1:0] fld_cnt_reg;
  logic [CNT_W-1:0] byte_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      fld_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
    end else begin
      if (in_fire)  fld_cnt_reg  <= fld_cnt_reg + CNT_W'(1);
      if (out_fire) byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
    end
  end

  assign fld_cnt  = fld_cnt_reg;
  assign byte_cnt = byte_cnt_reg;
`endif

endmodule

// File: tb/tb_zz_varint_seq.sv
// Self-checking bench for zz_varint_seq: directed protobuf vectors plus
// randomized fields checked against an arithmetic varint reference model.
module tb_zz_varint_seq;

  localparam int CNT_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_val = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        busy;
`ifdef ZZ_STATS_EN
  logic             stats_clr = 1'b0;
  logic [CNT_W-1:0] fld_cnt;
  logic [CNT_W-1:0] byte_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int bench_flds = 0;
  int bench_bytes = 0;

  typedef struct {
    logic [63:0] val;
    logic [1:0]  mode;
    int          n;      // 0: expected bytes come from the reference model
    logic [79:0] b;      // hand-written expected bytes, byte 0 in [7:0]
  } fld_t;

  fld_t       pend[$];
  logic [8:0] exp_q[$];  // {last, byte}

  zz_varint_seq #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_val    (in_val),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .busy      (busy)
`ifdef ZZ_STATS_EN
    ,
    .stats_clr (stats_clr),
    .fld_cnt   (fld_cnt),
    .byte_cnt  (byte_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Protobuf value semantics written as signed arithmetic.
  function automatic logic [63:0] ref_xform(input logic [63:0] v, input logic [1:0] m);
    longint s;
    int     s32;
    case (m)
      2'd1: begin s32 = v[31:0]; s = s32; return s; end
      2'd2: begin s32 = v[31:0]; s = s32; return (s >= 0) ? 2 * s : -2 * s - 1; end
      2'd3: begin s = v; return (s >= 0) ? 2 * s : -2 * s - 1; end
      default: return v;
    endcase
  endfunction

  task automatic push_model(input logic [63:0] v);
    logic [63:0] rem;
    logic [7:0]  grp;
    rem = v;
    do begin
      grp = 8'(rem % 128);
      rem = rem / 128;
      exp_q.push_back({rem == 0, rem != 0, grp[6:0]});
    end while (rem != 0);
  endtask

  task automatic push_fixed(input fld_t f);
    for (int i = 0; i < f.n; i++)
      exp_q.push_back({i == f.n - 1, f.b[8*i +: 8]});
  endtask

  task automatic add_field(input logic [63:0] v, input logic [1:0] m, input int n, input logic [79:0] b);
    fld_t f;
    f.val = v; f.mode = m; f.n = n; f.b = b;
    pend.push_back(f);
  endtask

  // Drives queued fields with the given valid/ready densities and checks every byte.
  task automatic run_fields(input int rdy_pct, input int vld_pct);
    bit         stall_prev = 0;
    bit         seen = 0;
    bit         full;
    logic [7:0] byte_prev = '0;
    logic [8:0] e;
    fld_t       f;
    full = (rdy_pct >= 100) && (vld_pct >= 100);
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (pend.size() > 0 && $urandom_range(99) < vld_pct) begin
        in_valid = 1'b1; in_val = pend[0].val; in_mode = pend[0].mode;
      end else begin
        in_valid = 1'b0; in_val = {$urandom, $urandom}; in_mode = 2'($urandom);
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (stall_prev) begin
        check("hold_byte", out_byte, byte_prev);
        check("hold_valid", out_valid, 1);
      end
      if (full && seen && exp_q.size() > 0) check("no_bubble", out_valid, 1);
      if (out_valid && !out_ready) check("bp_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_byte", out_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("out_byte", out_byte, e[7:0]);
          check("out_last", out_last, e[8]);
          bench_bytes++;
        end
      end
      if (in_valid && in_ready) begin
        f = pend.pop_front();
        if (f.n == 0) push_model(ref_xform(f.val, f.mode));
        else push_fixed(f);
        bench_flds++;
        seen = 1;
        $display("field val=%h mode=%0d queued_bytes=%0d", f.val, f.mode, exp_q.size());
      end
      stall_prev = out_valid && !out_ready;
      byte_prev = out_byte;
      @(posedge clk); #1;
      if (pend.size() == 0 && exp_q.size() == 0) break;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("drain_fields", pend.size(), 0);
    check("drain_bytes", exp_q.size(), 0);
    pend.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] edges [7];
    logic [63:0] v;
    edges[0] = 64'd0;
    edges[1] = 64'd1;
    edges[2] = 64'd127;
    edges[3] = 64'd128;
    edges[4] = 64'h7FFF_FFFF_FFFF_FFFF;
    edges[5] = 64'h8000_0000_0000_0000;
    edges[6] = 64'hFFFF_FFFF_FFFF_FFFF;

    // Reset cycle and post-reset idle state.
    rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_last", out_last, 1);
    check("rst_out_byte", out_byte, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_out_last", out_last, 1);
    check("idle_out_byte", out_byte, 0);
    @(posedge clk); #1;

    // Directed vectors with hand-computed encodings, streamed back-to-back.
    add_field(64'hFFFF_FFFF, 2'd2, 1, 80'h01);
    add_field(64'hFFFF_FFFF_FFFF_FFFE, 2'd3, 1, 80'h03);
    add_field(64'd300, 2'd0, 2, 80'h02AC);
    add_field(64'd0, 2'd0, 1, 80'h00);
    add_field(64'hFFFF_FFFF, 2'd1, 10, 80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF);
    add_field(64'h7FFF_FFFF, 2'd2, 5, 80'h0F_FF_FF_FF_FE);
    add_field(64'hDEAD_BEEF_0000_0001, 2'd2, 1, 80'h02);
    add_field(64'd1, 2'd0, 1, 80'h01);
    add_field(64'd150, 2'd0, 2, 80'h01_96);
    run_fields(100, 100);

    // Backpressure on UINT 300 after the first byte is presented.
    in_valid = 1'b1; in_val = 64'd300; in_mode = 2'd0; out_ready = 1'b0;
    @(negedge clk);
    check("bp_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_byte", out_byte, 8'hAC);
      check("bp_last", out_last, 0);
      check("bp_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_byte0", out_byte, 8'hAC);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_rel_byte1", out_byte, 8'h02);
    check("bp_rel_last", out_last, 1);
    check("bp_rel_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_done_valid", out_valid, 0);
    @(posedge clk); #1;

    // Randomized fields with random handshakes, then at full rate.
    for (int k = 0; k < 250; k++) begin
      case ($urandom_range(3))
        0: v = {$urandom, $urandom};
        1: v = {$urandom, $urandom} >> $urandom_range(63);
        2: v = ~({$urandom, $urandom} >> $urandom_range(63));
        default: v = edges[$urandom_range(6)];
      endcase
      add_field(v, 2'($urandom), 0, '0);
      if (k == 149) run_fields(65, 80);
    end
    run_fields(100, 100);

    // Reset while the second byte of a 10-byte varint is presented.
    in_valid = 1'b1; in_val = 64'hFFFF_FFFF; in_mode = 2'd1; out_ready = 1'b1;
    @(negedge clk);
    check("mid_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_byte0", out_byte, 8'hFF);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_last", out_last, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    bench_flds = 0;
    bench_bytes = 0;
    @(negedge clk);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    add_field(64'd5, 2'd0, 1, 80'h05);
    run_fields(100, 100);

`ifdef ZZ_STATS_EN
    check("stats_fld", fld_cnt, 64'(bench_flds));
    check("stats_byte", byte_cnt, 64'(bench_bytes));
    check("stats_fld_one", fld_cnt, 1);
    check("stats_byte_one", byte_cnt, 1);
    // Clear coincides with an input handshake; the clear must win.
    stats_clr = 1'b1; in_valid = 1'b1; in_val = 64'd0; in_mode = 2'd0; out_ready = 1'b1;
    @(negedge clk);
    check("clr_accept", in_ready, 1);
    @(posedge clk); #1;
    stats_clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clr_fld", fld_cnt, 0);
    check("clr_byte", byte_cnt, 0);
    check("clr_zero_byte", out_byte, 8'h00);
    check("clr_zero_last", out_last, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("clr_byte_inc", byte_cnt, 1);
    check("clr_fld_hold", fld_cnt, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
